baud_tick_generator: RTL and testbench

Programmable oversampling tick generator for the UART. It replaces the fixed-rate baud counter with one whose divisor the host writes at run time, with optional fractional division for accurate rates at any system clock. It produces the oversample tick and aligned bit-rate and mid-bit strobes. The RX path can resynchronise its phase on a start-bit edge. It sits between the system clock domain and the UART RX/TX state machines.

---
 rtl/baud_tick_generator.sv | 191 +++++++++++++++++++
 tb/tb_baud_tick_generator.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/baud_tick_generator.sv
// baud_tick_generator
//
// Programmable oversampling tick generator for the UART. The host writes a
// fixed-point divisor (integer part in the upper NB_DIV_INT bits, fraction in
// the lower NB_DIV_FRAC bits) at run time. Each oversample period lasts
// int (+1 when the fractional accumulator carries) system clocks. Bit-centre
// and end-of-bit strobes are decoded from the oversample counter. The RX path
// can restart the tick/bit phase with i_sync on a start-bit edge.
//
// Optional feature macro: BAUD_TICK_FRAC_EN
//   defined   - fractional accumulator present, period alternates int / int+1
//   undefined - fraction bits of i_div_data and DEFAULT_DIV are ignored, N = int
//
// Ports:
//   i_clock      system clock, rising edge
//   i_reset_n    asynchronous active-low reset
//   i_enable     low freezes all counters and suppresses all ticks
//   i_sync       single-cycle pulse restarting the tick and bit phase
//   i_div_valid  divisor write request
//   i_div_data   new divisor, fixed point {int, frac}
//   o_div_ack    one-cycle pulse the cycle after a written divisor goes active
//   o_tick       oversample tick, one cycle wide
//   o_mid_tick   tick at the bit centre
//   o_bit_tick   tick at the end of each bit
module baud_tick_generator #(
  parameter int SYS_CLOCK   = 100000000,
  parameter int BAUD_RATE   = 9600,
  parameter int OVERSAMPLE  = 16,
  parameter int NB_DIV_INT  = 16,
  parameter int NB_DIV_FRAC = 4,
  parameter logic [NB_DIV_INT+NB_DIV_FRAC-1:0] DEFAULT_DIV =
    (NB_DIV_INT+NB_DIV_FRAC)'(
      (64'(SYS_CLOCK) * (64'd1 << NB_DIV_FRAC) + 64'(BAUD_RATE * OVERSAMPLE) / 64'd2)
      / 64'(BAUD_RATE * OVERSAMPLE))
) (
  input  logic                              i_clock,
  input  logic                              i_reset_n,
  input  logic                              i_enable,
  input  logic                              i_sync,
  input  logic                              i_div_valid,
  input  logic [NB_DIV_INT+NB_DIV_FRAC-1:0] i_div_data,
  output logic                              o_div_ack,
  output logic                              o_tick,
  output logic                              o_mid_tick,
  output logic                              o_bit_tick
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [NB_DIV_INT-1:0] INT_MIN = NB_DIV_INT'(2);
  localparam logic [NB_DIV_INT-1:0] INT_ONE = NB_DIV_INT'(1);

  // Integer divisors below 2 would make a zero/one-cycle period; treat them as 2.
  function automatic logic [NB_DIV_INT-1:0] clamp_int(input logic [NB_DIV_INT-1:0] v);
    return (v < INT_MIN) ? INT_MIN : v;
  endfunction

  localparam logic [NB_DIV_INT-1:0] DEF_INT = clamp_int(DEFAULT_DIV[NB_DIV_INT+NB_DIV_FRAC-1:NB_DIV_FRAC]);

  logic [NB_DIV_INT-1:0] div_int_q, div_int_d;
  logic [NB_DIV_INT-1:0] shadow_int_q, shadow_int_d;
  logic                  pending_q, pending_d;
  logic [NB_DIV_INT-1:0] cnt_q, cnt_d;
  logic [OS_W-1:0]       os_q, os_d;
  logic                  ack_q, ack_d;

`ifdef BAUD_TICK_FRAC_EN
  localparam logic [NB_DIV_FRAC-1:0] DEF_FRAC = DEFAULT_DIV[NB_DIV_FRAC-1:0];

  logic [NB_DIV_FRAC-1:0] div_frac_q, div_frac_d;
  logic [NB_DIV_FRAC-1:0] shadow_frac_q, shadow_frac_d;
  logic [NB_DIV_FRAC-1:0] acc_q, acc_d;
  logic                   extra_q, extra_d;
`else
  // Fraction bits are deliberately ignored in the integer-only build.
  logic unused_frac;
  assign unused_frac = ^i_div_data[NB_DIV_FRAC-1:0];
`endif

  logic [NB_DIV_INT-1:0] period_last;
  logic                  terminal;
  logic                  tick;
  logic                  apply;

  // Terminal count is N-1 where N = int + extra. int >= 2, so N-1 never
  // underflows and int-1+extra always fits in NB_DIV_INT bits.
`ifdef BAUD_TICK_FRAC_EN
  assign period_last = div_int_q - INT_ONE + {{(NB_DIV_INT-1){1'b0}}, extra_q};
`else
  assign period_last = div_int_q - INT_ONE;
`endif

  assign terminal = (cnt_q == period_last);
  // Sync wins over a coincident terminal count, so no tick is issued then.
  assign tick     = i_enable & terminal & ~i_sync;
  assign apply    = pending_q & (tick | i_sync);

  assign o_tick     = tick;
  assign o_mid_tick = tick & (os_q == OS_MID);
  assign o_bit_tick = tick & (os_q == OS_LAST);
  assign o_div_ack  = ack_q;

  // Next-state logic. A write in the same cycle as an application refills the
  // shadow and keeps pending set, so the later write is applied next.
  always_comb begin
    div_int_d    = div_int_q;
    shadow_int_d = shadow_int_q;
    pending_d    = pending_q;
    cnt_d        = cnt_q;
    os_d         = os_q;
    ack_d        = apply;
`ifdef BAUD_TICK_FRAC_EN
    div_frac_d    = div_frac_q;
    shadow_frac_d = shadow_frac_q;
    acc_d         = acc_q;
    extra_d       = extra_q;
`endif

    if (apply) begin
      div_int_d = clamp_int(shadow_int_q);
      pending_d = 1'b0;
`ifdef BAUD_TICK_FRAC_EN
      div_frac_d = shadow_frac_q;
`endif
    end

    if (i_div_valid) begin
      shadow_int_d = i_div_data[NB_DIV_INT+NB_DIV_FRAC-1:NB_DIV_FRAC];
      pending_d    = 1'b1;
`ifdef BAUD_TICK_FRAC_EN
      shadow_frac_d = i_div_data[NB_DIV_FRAC-1:0];
`endif
    end

    if (i_sync) begin
      cnt_d = '0;
      os_d  = '0;
`ifdef BAUD_TICK_FRAC_EN
      acc_d   = '0;
      extra_d = 1'b0;
`endif
    end else if (tick) begin
      cnt_d = '0;
      os_d  = (os_q == OS_LAST) ? '0 : os_q + OS_W'(1);
`ifdef BAUD_TICK_FRAC_EN
      // A freshly applied divisor starts with a clean accumulator; otherwise
      // the carry out of acc + frac stretches the next period by one cycle.
      if (apply) begin
        acc_d   = '0;
        extra_d = 1'b0;
      end else begin
        {extra_d, acc_d} = {1'b0, acc_q} + {1'b0, div_frac_q};
      end
`endif
    end else if (i_enable) begin
      cnt_d = cnt_q + INT_ONE;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      div_int_q    <= DEF_INT;
      shadow_int_q <= '0;
      pending_q    <= 1'b0;
      cnt_q        <= '0;
      os_q         <= '0;
      ack_q        <= 1'b0;
`ifdef BAUD_TICK_FRAC_EN
      div_frac_q    <= DEF_FRAC;
      shadow_frac_q <= '0;
      acc_q         <= '0;
      extra_q       <= 1'b0;
`endif
    end else begin
      div_int_q    <= div_int_d;
      shadow_int_q <= shadow_int_d;
      pending_q    <= pending_d;
      cnt_q        <= cnt_d;
      os_q         <= os_d;
      ack_q        <= ack_d;
`ifdef BAUD_TICK_FRAC_EN
      div_frac_q    <= div_frac_d;
      shadow_frac_q <= shadow_frac_d;
      acc_q         <= acc_d;
      extra_q       <= extra_d;
`endif
    end
  end

endmodule

// File: tb/tb_baud_tick_generator.sv
// Testbench for baud_tick_generator with default parameters (divisor reset
// value 651 + 1/16). Directed vectors with hand-computed expected cycle
// numbers. Cycle numbering: the cycle in which i_sync is driven is cycle 0,
// so with divisor N the first tick lands in cycle N.
module tb_baud_tick_generator;

  localparam int DIV_W = 20;

  logic             i_clock = 1'b0;
  logic             i_reset_n;
  logic             i_enable;
  logic             i_sync;
  logic             i_div_valid;
  logic [DIV_W-1:0] i_div_data;
  logic             o_div_ack;
  logic             o_tick;
  logic             o_mid_tick;
  logic             o_bit_tick;

  int check_count = 0;
  int error_count = 0;

  baud_tick_generator dut (
    .i_clock     (i_clock),
    .i_reset_n   (i_reset_n),
    .i_enable    (i_enable),
    .i_sync      (i_sync),
    .i_div_valid (i_div_valid),
    .i_div_data  (i_div_data),
    .o_div_ack   (o_div_ack),
    .o_tick      (o_tick),
    .o_mid_tick  (o_mid_tick),
    .o_bit_tick  (o_bit_tick)
  );

  always #5 i_clock = ~i_clock;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drives inputs 1 time unit after the rising edge and returns 4 units later,
  // mid-cycle, where outputs are sampled.
  task automatic applyStimulus(input logic en, input logic sync, input logic valid,
                               input logic [DIV_W-1:0] data);
    @(posedge i_clock);
    #1;
    i_enable    = en;
    i_sync      = sync;
    i_div_valid = valid;
    i_div_data  = data;
    #3;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
  endtask

  // Number of cycles until the next o_tick; -1 when the budget runs out.
  task automatic measureTick(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      idleCycle();
      if (o_tick) begin
        n = i;
        break;
      end
    end
  endtask

  // Write a divisor, then sync so it applies at once; returns in cycle 0.
  task automatic loadDivisor(input logic [DIV_W-1:0] div);
    applyStimulus(1'b1, 1'b0, 1'b1, div);
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
  endtask

  // The release cycle itself is cycle 1 (cnt == 0).
  task automatic releaseReset();
    @(posedge i_clock);
    #1;
    i_reset_n   = 1'b1;
    i_enable    = 1'b1;
    i_sync      = 1'b0;
    i_div_valid = 1'b0;
    #3;
  endtask

  initial begin
    int n;
    int ticks, first_tick, second_tick, third_tick, after_gap;
    int first_mid, first_bit, second_bit, acks, ack_cycle, gap_ticks;

    i_reset_n   = 1'b0;
    i_enable    = 1'b0;
    i_sync      = 1'b0;
    i_div_valid = 1'b0;
    i_div_data  = '0;

    // Reset state
    repeat (3) @(posedge i_clock);
    #4;
    checkOutput("reset_tick", o_tick, 0);
    checkOutput("reset_mid_tick", o_mid_tick, 0);
    checkOutput("reset_bit_tick", o_bit_tick, 0);
    checkOutput("reset_div_ack", o_div_ack, 0);

    // Default divisor 651: first tick in cycle 651 after release, then every 651
    releaseReset();
    checkOutput("release_cycle_tick", o_tick, 0);
    measureTick(2000, n);
    checkOutput("reset_first_tick_cycle", (n < 0) ? 0 : n + 1, 651);
    measureTick(2000, n);
    checkOutput("default_period", n, 651);

    // Divisor 4: tick every 4, mid at 32, bit at 64 and 128, ack in cycle 1
    loadDivisor(20'h00040);
    ticks = 0; first_tick = 0; first_mid = 0; first_bit = 0; second_bit = 0;
    acks = 0; ack_cycle = 0;
    for (int c = 1; c <= 135; c++) begin
      idleCycle();
      if (o_tick) begin
        if (c <= 64) ticks++;
        if (first_tick == 0) first_tick = c;
      end
      if (o_mid_tick && first_mid == 0) first_mid = c;
      if (o_bit_tick) begin
        if (first_bit == 0) first_bit = c;
        else if (second_bit == 0) second_bit = c;
      end
      if (o_div_ack) begin
        acks++;
        ack_cycle = c;
      end
    end
    checkOutput("div4_first_tick", first_tick, 4);
    checkOutput("div4_ticks_in_64", ticks, 16);
    checkOutput("div4_first_mid", first_mid, 32);
    checkOutput("div4_first_bit", first_bit, 64);
    checkOutput("div4_second_bit", second_bit, 128);
    checkOutput("div4_ack_count", acks, 1);
    checkOutput("div4_ack_cycle", ack_cycle, 1);

    // Cycle 136 is a terminal count (os would be 1): sync suppresses the tick,
    // then the next tick is 4 later and os restarts so mid lands at 32.
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkOutput("sync_at_terminal_tick", o_tick, 0);
    first_tick = 0; first_mid = 0;
    for (int c = 1; c <= 40; c++) begin
      idleCycle();
      if (o_tick && first_tick == 0) first_tick = c;
      if (o_mid_tick && first_mid == 0) first_mid = c;
    end
    checkOutput("post_sync_first_tick", first_tick, 4);
    checkOutput("post_sync_first_mid", first_mid, 32);

    // Write 0x060 in cycle 2 of a 4-cycle period: ticks at 4 then 10, ack at 5
    first_tick = 0; second_tick = 0; acks = 0; ack_cycle = 0;
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    for (int c = 1; c <= 16; c++) begin
      if (c == 2) applyStimulus(1'b1, 1'b0, 1'b1, 20'h00060);
      else        idleCycle();
      if (o_tick) begin
        if (first_tick == 0) first_tick = c;
        else if (second_tick == 0) second_tick = c;
      end
      if (o_div_ack) begin
        acks++;
        ack_cycle = c;
      end
    end
    checkOutput("midwrite_first_tick", first_tick, 4);
    checkOutput("midwrite_second_tick", second_tick, 10);
    checkOutput("midwrite_ack_count", acks, 1);
    checkOutput("midwrite_ack_cycle", ack_cycle, 5);

    // Divisor 6, enable low in cycles 8..17: tick at 6, none in gap, next at 22
    first_tick = 0; after_gap = 0; gap_ticks = 0;
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    for (int c = 1; c <= 30; c++) begin
      applyStimulus((c >= 8 && c <= 17) ? 1'b0 : 1'b1, 1'b0, 1'b0, '0);
      if (o_tick) begin
        if (c >= 8 && c <= 17) gap_ticks++;
        if (first_tick == 0) first_tick = c;
        else if (c > 17 && after_gap == 0) after_gap = c;
      end
    end
    checkOutput("gap_first_tick", first_tick, 6);
    checkOutput("gap_ticks_while_disabled", gap_ticks, 0);
    checkOutput("gap_resume_tick", after_gap, 22);

    // Divisor 4.5: periods 4,4,5,4,5,... with the fraction, else 4 always
    loadDivisor(20'h00048);
    ticks = 0; third_tick = 0;
    for (int c = 1; c <= 72; c++) begin
      idleCycle();
      if (o_tick) begin
        ticks++;
        if (ticks == 3) third_tick = c;
      end
    end
`ifdef BAUD_TICK_FRAC_EN
    checkOutput("frac_ticks_in_72", ticks, 16);
    checkOutput("frac_third_tick", third_tick, 13);
`else
    checkOutput("frac_ticks_in_72", ticks, 18);
    checkOutput("frac_third_tick", third_tick, 12);
`endif

    // Integer part 1 is clamped to 2
    loadDivisor(20'h00010);
    ticks = 0; first_tick = 0;
    for (int c = 1; c <= 8; c++) begin
      idleCycle();
      if (o_tick) begin
        ticks++;
        if (first_tick == 0) first_tick = c;
      end
    end
    checkOutput("clamp_first_tick", first_tick, 2);
    checkOutput("clamp_ticks_in_8", ticks, 4);

    // Reset asserted while a tick is high aborts it; divisor returns to 651
    loadDivisor(20'h00060);
    for (int c = 1; c <= 6; c++) idleCycle();
    checkOutput("tick_before_reset", o_tick, 1);
    #2;
    i_reset_n = 1'b0;
    #1;
    checkOutput("async_reset_tick", o_tick, 0);
    checkOutput("async_reset_mid_tick", o_mid_tick, 0);
    checkOutput("async_reset_bit_tick", o_bit_tick, 0);
    checkOutput("async_reset_div_ack", o_div_ack, 0);
    repeat (2) @(posedge i_clock);
    releaseReset();
    measureTick(2000, n);
    checkOutput("rereset_first_tick_cycle", (n < 0) ? 0 : n + 1, 651);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
